// File: rtl/store_queue_unit.sv
// -----------------------------------------------------------------------------
// store_queue_unit
//
// Store unit: accepts stores from the LSU issue stage and requests address
// translation. Translated stores go into a DEPTH-entry circular queue that
// holds a speculative region (wr side) and a committed region (rd side).
// Committed stores drain to the D$ over a req/gnt port. The block also flags
// page-offset hazards against pending stores for loads.
//
// Queue layout (modulo DEPTH):
//   rd_ptr .. cm_ptr-1   committed entries (cm_cnt of them), oldest at rd_ptr
//   cm_ptr .. wr_ptr-1   speculative entries (sp_cnt of them)
//
// Optional feature macro: STQ_DRAIN_MERGE_EN
//   When defined, the two oldest committed entries are drained with a single
//   D$ request if they fall in the same 8-byte dword.
//
// Ports:
//   clk_i, rst_i             clock, asynchronous active-high reset
//   flush_i                  drop speculative state
//   valid_i / ready_o        store request / store popped this cycle
//   trans_id_i, vaddr_i,
//   data_i, be_i, size_i     store payload
//   translation_req_o,
//   vaddr_o                  MMU request
//   paddr_i, dtlb_hit_i,
//   ex_valid_i               MMU response
//   valid_o, trans_id_o,
//   ex_o                     writeback, one cycle after ready_o
//   commit_i, commit_ready_o commit oldest speculative store
//   dc_req_o, dc_addr_o,
//   dc_data_o, dc_be_o,
//   dc_size_o, dc_gnt_i      D$ write port
//   page_offset_i,
//   page_offset_matches_o    load hazard check
//   empty_o, no_st_pending_o queue status
// -----------------------------------------------------------------------------
module store_queue_unit #(
    parameter int DATA_W     = 64,
    parameter int PADDR_W    = 56,
    parameter int VADDR_W    = 39,
    parameter int DEPTH      = 8,
    parameter int TRANS_ID_W = 3
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  flush_i,
    input  logic                  valid_i,
    output logic                  ready_o,
    input  logic [TRANS_ID_W-1:0] trans_id_i,
    input  logic [VADDR_W-1:0]    vaddr_i,
    input  logic [DATA_W-1:0]     data_i,
    input  logic [DATA_W/8-1:0]   be_i,
    input  logic [1:0]            size_i,
    output logic                  translation_req_o,
    output logic [VADDR_W-1:0]    vaddr_o,
    input  logic [PADDR_W-1:0]    paddr_i,
    input  logic                  dtlb_hit_i,
    input  logic                  ex_valid_i,
    output logic                  valid_o,
    output logic [TRANS_ID_W-1:0] trans_id_o,
    output logic                  ex_o,
    input  logic                  commit_i,
    output logic                  commit_ready_o,
    output logic                  dc_req_o,
    output logic [PADDR_W-1:0]    dc_addr_o,
    output logic [DATA_W-1:0]     dc_data_o,
    output logic [DATA_W/8-1:0]   dc_be_o,
    output logic [1:0]            dc_size_o,
    input  logic                  dc_gnt_i,
    input  logic [11:0]           page_offset_i,
    output logic                  page_offset_matches_o,
    output logic                  empty_o,
    output logic                  no_st_pending_o
);

    localparam int BE_W  = DATA_W / 8;
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic {
        IDLE,
        WAIT_TRANSLATION
    } state_t;

    state_t state_q;

    logic [PTR_W-1:0] rd_ptr, cm_ptr, wr_ptr;
    logic [CNT_W-1:0] cm_cnt, sp_cnt, total;

    logic [PADDR_W-1:0] mem_paddr [DEPTH];
    logic [DATA_W-1:0]  mem_data  [DEPTH];
    logic [BE_W-1:0]    mem_be    [DEPTH];
    logic [1:0]         mem_size  [DEPTH];

    logic             accept_fire;
    logic             write_en;
    logic             commit_fire;
    logic             pop_fire;
    logic [CNT_W-1:0] drain_n;
    logic [CNT_W-1:0] pop_amt;
    logic [PTR_W-1:0] occ_off;
    logic             hazard;
    logic             unused_offset_bits;

    assign total = cm_cnt + sp_cnt;

    // A store is popped on a hit in IDLE; an exception pops it even when the
    // queue is full because nothing gets written.
    assign accept_fire = (state_q == IDLE) && valid_i && dtlb_hit_i &&
                         (ex_valid_i || (total != CNT_W'(DEPTH)));
    assign write_en    = accept_fire && !ex_valid_i && !flush_i;
    assign commit_fire = commit_i && (sp_cnt != '0);

    assign ready_o           = accept_fire;
    assign translation_req_o = (state_q == WAIT_TRANSLATION) || valid_i;
    assign vaddr_o           = vaddr_i;
    assign commit_ready_o    = (sp_cnt != '0);
    assign dc_req_o          = (cm_cnt != '0);
    assign pop_fire          = dc_req_o && dc_gnt_i;
    assign pop_amt           = pop_fire ? drain_n : '0;
    assign empty_o           = (total == '0);
    assign no_st_pending_o   = (cm_cnt == '0);

`ifdef STQ_DRAIN_MERGE_EN
    logic [PTR_W-1:0] rd_ptr_nxt;
    logic             merge;

    assign rd_ptr_nxt = rd_ptr + PTR_W'(1);
    assign merge      = (cm_cnt >= CNT_W'(2)) &&
                        (mem_paddr[rd_ptr][PADDR_W-1:3] == mem_paddr[rd_ptr_nxt][PADDR_W-1:3]);
`endif

    // D$ request payload; held at zero while nothing is committed.
    always_comb begin
        dc_addr_o = '0;
        dc_data_o = '0;
        dc_be_o   = '0;
        dc_size_o = '0;
        drain_n   = CNT_W'(1);
        if (dc_req_o) begin
            dc_addr_o = mem_paddr[rd_ptr];
            dc_data_o = mem_data[rd_ptr];
            dc_be_o   = mem_be[rd_ptr];
            dc_size_o = mem_size[rd_ptr];
`ifdef STQ_DRAIN_MERGE_EN
            if (merge) begin
                dc_addr_o = {mem_paddr[rd_ptr][PADDR_W-1:3], 3'b000};
                dc_be_o   = mem_be[rd_ptr] | mem_be[rd_ptr_nxt];
                dc_size_o = 2'd3;
                drain_n   = CNT_W'(2);
                // younger store wins on overlapping bytes
                for (int b = 0; b < BE_W; b++) begin
                    dc_data_o[b*8 +: 8] = mem_be[rd_ptr_nxt][b] ? mem_data[rd_ptr_nxt][b*8 +: 8]
                                                                : mem_data[rd_ptr][b*8 +: 8];
                end
            end
`endif
        end
    end

    // Occupied slots are the 'total' slots starting at rd_ptr.
    always_comb begin
        hazard  = valid_i && (vaddr_i[11:3] == page_offset_i[11:3]);
        occ_off = '0;
        for (int i = 0; i < DEPTH; i++) begin
            occ_off = PTR_W'(i) - rd_ptr;
            if (({1'b0, occ_off} < total) && (mem_paddr[i][11:3] == page_offset_i[11:3]))
                hazard = 1'b1;
        end
    end

    assign page_offset_matches_o = hazard;
    assign unused_offset_bits    = ^page_offset_i[2:0];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            rd_ptr     <= '0;
            cm_ptr     <= '0;
            wr_ptr     <= '0;
            cm_cnt     <= '0;
            sp_cnt     <= '0;
            valid_o    <= 1'b0;
            ex_o       <= 1'b0;
            trans_id_o <= '0;
        end else begin
            if (flush_i) begin
                state_q <= IDLE;
            end else begin
                unique case (state_q)
                    IDLE:             if (valid_i && !dtlb_hit_i) state_q <= WAIT_TRANSLATION;
                    WAIT_TRANSLATION: if (dtlb_hit_i) state_q <= IDLE;
                    default:          state_q <= IDLE;
                endcase
            end

            valid_o <= accept_fire && !flush_i;
            ex_o    <= accept_fire && ex_valid_i && !flush_i;
            if (accept_fire)
                trans_id_o <= trans_id_i;

            if (pop_fire)
                rd_ptr <= rd_ptr + PTR_W'(drain_n);
            cm_ptr <= cm_ptr + PTR_W'(commit_fire);
            cm_cnt <= cm_cnt + CNT_W'(commit_fire) - pop_amt;

            // Flush rewinds the write side onto the committed boundary,
            // including a commit taken in the same cycle.
            if (flush_i) begin
                wr_ptr <= cm_ptr + PTR_W'(commit_fire);
                sp_cnt <= '0;
            end else begin
                wr_ptr <= wr_ptr + PTR_W'(write_en);
                sp_cnt <= sp_cnt + CNT_W'(write_en) - CNT_W'(commit_fire);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (write_en) begin
            mem_paddr[wr_ptr] <= paddr_i;
            mem_data[wr_ptr]  <= data_i;
            mem_be[wr_ptr]    <= be_i;
            mem_size[wr_ptr]  <= size_i;
        end
    end

endmodule
